// File: rtl/mips_pkg.sv
// Shared MIPS encodings: multiply/divide op codes and the MDU FSM states.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff;

  assign sh     = {rem_i, msb_i};
  // Any successful subtraction leaves less than the divisor, so W bits suffice.
  assign diff   = sh[WIDTH-1:0] - dvs_i;
  assign qbit_o = (sh >= {1'b0, dvs_i});
  assign rem_o  = qbit_o ? diff : sh[WIDTH-1:0];
endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit: radix-2 shift-add MULT and restoring DIV
// on magnitudes, one bit per cycle, committing HI/LO on the final iteration.
module mdu_iter
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;    // product high half / partial remainder
  logic [WIDTH-1:0] mq_q, mq_d;      // multiplier or dividend out, result bits in
  logic [WIDTH-1:0] opb_q, opb_d;    // multiplicand / divisor magnitude
  logic [WIDTH-1:0] araw_q, araw_d;  // raw dividend for the divide-by-zero result
  logic             neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic               sgn, a_neg, b_neg, dqbit;
  logic [WIDTH-1:0]   a_mag, b_mag, drem, quo, rem;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] prod;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_q),
    .msb_i (mq_q[WIDTH-1]),
    .dvs_i (opb_q),
    .rem_o (drem),
    .qbit_o(dqbit)
  );

  always_comb begin
    sgn   = (op == OP_MULT) || (op == OP_DIV);
    a_neg = sgn && a[WIDTH-1];
    b_neg = sgn && b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    msum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
    // Final results are formed from this cycle's step output so the last
    // iteration and the commit share one edge.
    prod  = {msum, mq_q[WIDTH-1:1]};
    if (neg_q) prod = -prod;
    quo   = {mq_q[WIDTH-2:0], dqbit};
    if (neg_q) quo = -quo;
    rem   = rneg_q ? -drem : drem;

    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    opb_d   = opb_q;
    araw_d  = araw_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: if (start && !flush) begin
        case (op)
          OP_MULT, OP_MULTU: begin
            state_d = ST_MUL;
            cnt_d   = '0;
            acc_d   = '0;
            opb_d   = a_mag;
            mq_d    = b_mag;
            neg_d   = a_neg ^ b_neg;
          end
          OP_DIV, OP_DIVU: begin
            state_d = ST_DIV;
            cnt_d   = '0;
            acc_d   = '0;
            opb_d   = b_mag;
            mq_d    = a_mag;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dz_d    = (b == '0);
            araw_d  = a;
          end
          OP_MTHI: hi_d = a;
          OP_MTLO: lo_d = a;
          default: ;
        endcase
      end
      ST_MUL: if (flush) begin
        state_d = ST_IDLE;
      end else begin
        acc_d = msum[WIDTH:1];
        mq_d  = {msum[0], mq_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          hi_d    = prod[2*WIDTH-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
          done_d  = 1'b1;
        end
      end
      ST_DIV: if (flush) begin
        state_d = ST_IDLE;
      end else begin
        acc_d = drem;
        mq_d  = {mq_q[WIDTH-2:0], dqbit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          hi_d    = dz_q ? araw_q : rem;
          lo_d    = dz_q ? '1 : quo;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      opb_q   <= '0;
      araw_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      opb_q   <= opb_d;
      araw_q  <= araw_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed plus randomized checks of mdu_iter against a plain-arithmetic HI/LO model.
module tb_mdu_iter;
  import mips_pkg::*;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] hi_m, lo_m;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural {hi,lo} after an op, from ordinary integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [W-1:0] x, y,
                                        input logic [W-1:0] h, l);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      OP_MULT:  return 64'(sx * sy);
      OP_MULTU: return ux * uy;
      OP_DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
      OP_MTHI: return {x, l};
      OP_MTLO: return {h, x};
      default: return {h, l};
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the cycle the result is visible.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, y, input string tag);
    logic [63:0] exp;
    int          bad;
    exp = model(o, x, y, hi_m, lo_m);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = OP_NOP; a = $urandom; b = $urandom;
    if (o inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
      bad = 0;
      for (int k = 1; k <= W; k++) begin
        if (busy !== 1'b1 || done !== 1'b0 || hi !== hi_m || lo !== lo_m) bad++;
        @(negedge clk);
      end
      chk({tag, " busy/hold"}, 64'(bad), 64'd0);
      chk({tag, " done"}, {63'b0, done}, 64'd1);
      chk({tag, " busy_end"}, {63'b0, busy}, 64'd0);
    end else begin
      chk({tag, " busy"}, {62'b0, busy, done}, 64'd0);
    end
    chk({tag, " hi"}, {32'b0, hi}, {32'b0, exp[63:32]});
    chk({tag, " lo"}, {32'b0, lo}, {32'b0, exp[31:0]});
    hi_m = exp[63:32];
    lo_m = exp[31:0];
  endtask

  task automatic idle(input int n, input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || hi !== hi_m || lo !== lo_m) bad++;
    end
    chk({tag, " idle"}, 64'(bad), 64'd0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = OP_NOP; a = '0; b = '0;
    hi_m = '0; lo_m = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", {63'b0, busy}, 64'd0);
    chk("reset done", {63'b0, done}, 64'd0);
    chk("reset hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, "mult_neg");
    chk("mult_neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    idle(1, "mult_neg pulse");

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    chk("multu_max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    // Back-to-back: each issues in the cycle the previous result appears.
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg7");
    chk("div_neg7 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_DIVU, 32'h0000_0064, 32'h0000_0000, "divu_zero");
    chk("divu_zero const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk("div_ovf const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0000, "div_zero_s");
    chk("div_zero_s const", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);
    idle(1, "div pulse");

    start = 1'b1; op = OP_MTHI; a = 32'h1234_5678;
    @(negedge clk);
    chk("mthi busy", {62'b0, busy, done}, 64'd0);
    op = OP_MTLO; a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    chk("mthi/mtlo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    chk("mtlo busy", {62'b0, busy, done}, 64'd0);
    hi_m = 32'h1234_5678; lo_m = 32'h9ABC_DEF0;

    start = 1'b1; op = OP_DIVU; a = $urandom; b = 32'($urandom_range(1, 1000));
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    repeat (4) @(negedge clk);
    chk("flush busy c5", {63'b0, busy}, 64'd1);
    start = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy c11", {62'b0, busy, done}, 64'd0);
    chk("flush hilo", {hi, lo}, {hi_m, lo_m});
    idle(40, "after flush");

    start = 1'b1; flush = 1'b1; op = OP_MTLO; a = 32'h5555_5555;
    @(negedge clk);
    op = OP_MULT; a = 32'd7; b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; op = OP_NOP;
    chk("flush+start", {62'b0, busy, done}, 64'd0);
    chk("flush+start hilo", {hi, lo}, {hi_m, lo_m});

    start = 1'b1; op = OP_MULT; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    repeat (14) @(negedge clk);
    rst = 1'b1; flush = 1'b1; start = 1'b1; op = OP_MTHI; a = 32'h1111_1111;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; start = 1'b0; op = OP_NOP;
    chk("rst mid busy", {62'b0, busy, done}, 64'd0);
    chk("rst mid hilo", {hi, lo}, 64'd0);
    hi_m = '0; lo_m = '0;
    idle(35, "after rst");
    @(negedge clk);
    run_op(OP_MULTU, 32'd3, 32'd4, "multu_3x4");
    chk("multu_3x4 const", {hi, lo}, 64'h0000_0000_0000_000C);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] ro;
      ro = 3'($urandom_range(0, 7));
      run_op(ro, pick(), pick(), $sformatf("rand%0d op%0d", i, ro));
    end
    idle(2, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and HI/LO register width (even, >= 8).
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, meaning the op request is valid this cycle.
REQ-005 The block SHALL have port op, input, 3, meaning the operation code from the shared package.
REQ-006 The block SHALL have port a, input, WIDTH, meaning the rs operand (dividend or multiplicand).
REQ-007 The block SHALL have port b, input, WIDTH, meaning the rt operand (divisor or multiplier).
REQ-008 The block SHALL have port flush, input, 1, meaning abort the in-flight op (branch or jump squash).
REQ-009 The block SHALL have port busy, output, 1, meaning an iterative op is in progress; the pipeline stalls MFHI/MFLO and MDU ops while it is high.
REQ-010 The block SHALL have port done, output, 1, meaning a one-cycle pulse on the cycle hi/lo first show a new iterative result.
REQ-011 The block SHALL have ports hi and lo, output, WIDTH each, meaning the architectural HI and LO registers.

Function
REQ-012 Op codes SHALL be: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 111 is treated as NOP.
REQ-013 The FSM SHALL have three states: IDLE, MUL, DIV.
REQ-014 IDLE transitions: start with MULT/MULTU goes to MUL; start with DIV/DIVU goes to DIV; in both cases operand magnitudes and result signs are latched and the iteration counter is cleared.
REQ-015 Start with MTHI or MTLO in IDLE SHALL write a to hi or lo at that edge, with no busy and no done.
REQ-016 MUL SHALL run radix-2 shift-add for exactly WIDTH cycles on unsigned magnitudes.
REQ-017 DIV SHALL run restoring division for exactly WIDTH cycles on unsigned magnitudes.
REQ-018 Latency: start accepted at edge 0; busy high during cycles 1..WIDTH; hi/lo and done valid in cycle WIDTH+1; busy low in cycle WIDTH+1; FSM back in IDLE.
REQ-019 Signed ops SHALL negate the product when the operand signs differ.
REQ-020 Signed divide SHALL give the quotient the sign of a XOR b and the remainder the sign of a, truncating toward zero.
REQ-021 Multiply results SHALL be hi = product[2W-1:W] and lo = product[W-1:0].
REQ-022 Divide results SHALL be lo = quotient and hi = remainder.
REQ-023 Divide by zero SHALL complete in normal latency with lo = all ones and hi = a, unmodified.
REQ-024 Signed divide of the most-negative value by -1 SHALL give lo = most-negative value and hi = 0, with no trap.
REQ-025 hi/lo SHALL NOT change during MUL/DIV; only the final edge commits.
REQ-026 Start while busy SHALL be ignored, including MTHI/MTLO; the upstream must not issue it.
REQ-027 Flush while busy SHALL return the FSM to IDLE at that edge; hi/lo keep prior values; done is not asserted; busy drops next cycle.
REQ-028 Flush and start in the same IDLE cycle: flush wins; the op is not accepted.
REQ-029 A new start is accepted in the cycle busy first reads low (back-to-back, WIDTH+1 cycle issue interval).

Reset
REQ-030 rst SHALL force, at the next edge: FSM = IDLE, busy = 0, done = 0, hi = 0, lo = 0, counter = 0.
REQ-031 rst asserted mid-operation SHALL abort the op with no commit; rst has priority over flush and start.

Structure
REQ-032 The op encodings and FSM state encodings SHALL live in the shared package mips_pkg, also used by ctrl.
REQ-033 One sub-module SHALL be natural: mdu_div_step, the combinational one-bit restoring-divide step (WIDTH-parametrised); the multiply step stays inline.

Verification (WIDTH=32)
REQ-034 The bench SHALL cover: MULT a=FFFFFFFD, b=00000005 -> after 33 cycles hi=FFFFFFFF, lo=FFFFFFF1, one done pulse.
REQ-035 The bench SHALL cover: MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-036 The bench SHALL cover: DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=64, b=0 -> lo=FFFFFFFF, hi=00000064.
REQ-037 The bench SHALL cover: MTHI a=12345678, then MTLO a=9ABCDEF0 on consecutive cycles -> hi=12345678, lo=9ABCDEF0 the next cycle, busy never high.
REQ-038 The bench SHALL cover: DIVU started, flush at cycle 10 -> hi/lo unchanged, no done, busy low by cycle 11; a start during busy is ignored.
REQ-039 The bench SHALL cover: rst at cycle 15 of a MULT -> hi=lo=0, busy=0 next cycle; a following MULTU 3x4 -> lo=0000000C.
